// File: rtl/bankregister_param.sv
// Parametrised 2-read/1-write register bank with post-reset init sweep,
// registered reads and hardwired-zero entry 0. Define REGFILE_BYPASS_EN for write-first bypass.
module bankregister_param #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 5,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RegLe1,
    input  logic [ADDR_W-1:0] RegLe2,
    input  logic [ADDR_W-1:0] RegEscr,
    input  logic              EscrReg,
    input  logic [DATA_W-1:0] datain,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    // state | meaning
    // INIT  | sweeping INIT_VALUE into entries 1..DEPTH-1, bank unusable
    // RUN   | normal read/write operation
    typedef enum logic {INIT, RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   data1_q, data1_d;
    logic [DATA_W-1:0]   data2_q, data2_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic                user_wr;
    logic [DATA_W-1:0]   rd1, rd2;

    assign user_wr = EscrReg && (RegEscr != '0);

    // Entry 0 is never written, so reads of address 0 are forced to zero here.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (RegLe1 != '0) rd1 = mem_q[RegLe1];
        if (RegLe2 != '0) rd2 = mem_q[RegLe2];
`ifdef REGFILE_BYPASS_EN
        if (user_wr && (RegLe1 == RegEscr)) rd1 = datain;
        if (user_wr && (RegLe2 == RegEscr)) rd2 = datain;
`endif
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        data1_d   = '0;
        data2_d   = '0;
        mem_we    = 1'b0;
        mem_waddr = RegEscr;
        mem_wdata = datain;
        case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = INIT_VALUE;
                ptr_d     = ptr_q + ADDR_W'(1);
                if (ptr_q == LAST) begin
                    state_d = RUN;
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                data1_d = rd1;
                data2_d = rd2;
                mem_we  = user_wr;
            end
            default: begin
                state_d = INIT;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            ptr_q   <= ADDR_W'(1);
            busy_q  <= 1'b1;
            data1_q <= '0;
            data2_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
        end
    end

    // Storage is deliberately not reset; the sweep defines every readable entry.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem_q[mem_waddr] <= mem_wdata;
    end

    assign data1 = data1_q;
    assign data2 = data2_q;
    assign busy  = busy_q;

endmodule

// File: doc/bankregister_param.md
Name: bankregister_param

Overview:
- Parametrised successor of the processor's 2-read/1-write register bank, generalised in data width and depth.
- Adds a post-reset initialisation sweep (one entry per cycle, with a busy flag), registered reads, and a hardwired zero for entry 0.
- Optional same-cycle write-to-read bypass.
- Sits between instruction decode (read addresses), the ALU (operands) and writeback (write port).

Parameters:
- DATA_W, 32, width of each register and data port.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries (localparam).
- INIT_VALUE, 0, value written to entries 1..DEPTH-1 by the init sweep.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- RegLe1  input  ADDR_W  read address, port 1.
- RegLe2  input  ADDR_W  read address, port 2.
- RegEscr  input  ADDR_W  write address.
- EscrReg  input  1  write enable.
- datain  input  DATA_W  write data.
- data1  output  DATA_W  registered read data, port 1.
- data2  output  DATA_W  registered read data, port 2.
- busy  output  1  high while the init sweep runs; the bank is unusable while high.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- States: INIT, RUN.
- Reset, sampled at a clk edge with reset=1:
  - state<=INIT, sweep pointer ptr<=1, data1<=0, data2<=0, busy<=1.
  - Reset asserted mid-sweep or mid-RUN restarts the sweep from ptr=1. Register contents are not cleared in bulk.
- INIT, reset=0, each edge:
  - register[ptr]<=INIT_VALUE, then ptr<=ptr+1.
  - On the edge that writes ptr=DEPTH-1: state<=RUN, busy<=0.
  - The sweep takes exactly DEPTH-1 edges after reset deasserts (31 for the defaults). ptr never wraps.
  - EscrReg, RegEscr and datain are ignored. data1 and data2 are held at 0.
- RUN, each edge:
  - data1<=register[RegLe1] and data2<=register[RegLe2], using pre-edge contents (read-before-write) unless bypass is compiled in.
  - Read latency: 1 cycle from address to data.
  - If EscrReg=1 and RegEscr!=0: register[RegEscr]<=datain.
  - If EscrReg=0: no entry changes; the old "write back own value" behaviour is not reproduced.
- Entry 0:
  - Reads always return 0, in every state and with or without bypass.
  - Writes to address 0 are discarded. No storage for entry 0 is required.
- Both read ports may address the same entry and return identical data.
- No X may propagate to data1/data2 after the first reset edge, even for entries not yet swept.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in RUN, if EscrReg=1, RegEscr!=0 and RegLeN==RegEscr, dataN<=datain on the same edge (write-first). Applies to each read port independently.
- Not defined: that read returns the pre-write value; the new value is visible on the next read.
- The write to the array happens identically in both builds.

Test Plan:
- Reset sweep: hold reset 2 cycles with INIT_VALUE=32'h0000_0001, release → busy=1 for exactly 31 edges, then 0. Reads of entries 1..31 return 1; entry 0 returns 0. data1/data2 are 0 throughout the sweep.
- Basic write/read: write 32'hDEAD_BEEF to entry 5, next cycle RegLe1=5 and RegLe2=5 → both data1 and data2 = 32'hDEAD_BEEF one cycle later.
- Zero register: write 32'hFFFF_FFFF to entry 0, then RegLe1=0 → data1=0. Writes with EscrReg=0 to entry 7 leave its value unchanged.
- Simultaneous read/write: RegEscr=9, datain=32'h1234_5678, EscrReg=1, RegLe1=9 (entry 9 previously 32'h0000_00AA) → data1=32'h0000_00AA without REGFILE_BYPASS_EN, 32'h1234_5678 with it. The following read returns 32'h1234_5678 in both builds.
- Writes during INIT: assert EscrReg=1, RegEscr=3, datain=32'h55 during the sweep → ignored; entry 3 reads INIT_VALUE after busy falls.
- Reset mid-sweep: assert reset at sweep edge 10 for 1 cycle → busy stays high, and a full 31-edge sweep follows the release.
